// File: rtl/reg_wb_arbiter_pkg.sv
// Shared sizes, FSM encoding and requester ids for the register-file writeback arbiter.
package reg_wb_arbiter_pkg;

  localparam int NREG = 8;
  localparam int AW   = $clog2(NREG);
  localparam int DW   = 16;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [NREG-1:0] addr_onehot(input logic [AW-1:0] addr);
    logic [NREG-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Writeback requests, issue/read-port hazard queries and the register-file write port.
interface reg_wb_arbiter_if;
  import reg_wb_arbiter_pkg::*;

  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          issue_valid;
  logic [AW-1:0] issue_addr;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic          ra_haz;
  logic          rb_haz;
  logic          wd_haz;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          init_done;

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  issue_valid, issue_addr, raddr1, raddr2,
    output alu_ready, mem_ready, ra_haz, rb_haz, wd_haz,
    output we, waddr, wdata, init_done
  );

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output issue_valid, issue_addr, raddr1, raddr2,
    input  alu_ready, mem_ready, ra_haz, rb_haz, wd_haz,
    input  we, waddr, wdata, init_done
  );

endinterface

// File: rtl/reg_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2
  import reg_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_mem_r;

  // Grant selection; nothing is granted while the owner is not accepting writes.
  always_comb begin
    gnt = 2'b00;
    if (!advance) begin
      gnt = 2'b00;
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_mem_r ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Remember the last winner; resets to MEM so ALU takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_mem_r <= 1'b1;
    end else if (gnt[REQ_MEM]) begin
      last_mem_r <= 1'b1;
    end else if (gnt[REQ_ALU]) begin
      last_mem_r <= 1'b0;
    end else begin
      last_mem_r <= last_mem_r;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port owner: clears all registers after reset, then arbitrates
// ALU/MEM writebacks and tracks pending destinations for hazard stalls.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  reg_wb_arbiter_if.slave bus
);

  state_t          state_r;
  logic [AW-1:0]   init_cnt_r;
  logic            we_r;
  logic [AW-1:0]   waddr_r;
  logic [DW-1:0]   wdata_r;
  logic            init_done_r;
  logic [NREG-1:0] pend_r;

  logic            grant_en_s;
  logic [1:0]      gnt_s;
  logic [AW-1:0]   wr_addr_s;
  logic [DW-1:0]   wr_data_s;
  logic [NREG-1:0] clr_mask_s;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] pend_next_s;

  // Grants open only once the clear pass has fully landed in the register file.
  assign grant_en_s = (state_r == ST_RUN) && init_done_r;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({bus.mem_valid, bus.alu_valid}),
    .advance (grant_en_s),
    .gnt     (gnt_s)
  );

  assign bus.alu_ready = gnt_s[REQ_ALU];
  assign bus.mem_ready = gnt_s[REQ_MEM];
  assign bus.ra_haz    = pend_r[bus.raddr1];
  assign bus.rb_haz    = pend_r[bus.raddr2];
  assign bus.wd_haz    = pend_r[bus.issue_addr];
  assign bus.we        = we_r;
  assign bus.waddr     = waddr_r;
  assign bus.wdata     = wdata_r;
  assign bus.init_done = init_done_r;

  // Winning write and the scoreboard update; a new producer overrides a retiring one.
  always_comb begin
    wr_addr_s  = waddr_r;
    wr_data_s  = wdata_r;
    clr_mask_s = '0;
    set_mask_s = '0;
    case (gnt_s)
      2'b01: begin
        wr_addr_s  = bus.alu_addr;
        wr_data_s  = bus.alu_data;
        clr_mask_s = addr_onehot(bus.alu_addr);
      end
      2'b10: begin
        wr_addr_s  = bus.mem_addr;
        wr_data_s  = bus.mem_data;
        clr_mask_s = addr_onehot(bus.mem_addr);
      end
      default: begin
        wr_addr_s  = waddr_r;
        wr_data_s  = wdata_r;
        clr_mask_s = '0;
      end
    endcase
    if (grant_en_s && bus.issue_valid) begin
      set_mask_s = addr_onehot(bus.issue_addr);
    end else begin
      set_mask_s = '0;
    end
    pend_next_s = (pend_r & ~clr_mask_s) | set_mask_s;
  end

  // Clear sequence, then one registered write per accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= '0;
      we_r        <= 1'b0;
      waddr_r     <= '0;
      wdata_r     <= '0;
      init_done_r <= 1'b0;
      pend_r      <= '0;
    end else begin
      case (state_r)
        ST_INIT: begin
          we_r       <= 1'b1;
          waddr_r    <= init_cnt_r;
          wdata_r    <= '0;
          init_cnt_r <= init_cnt_r + {{(AW-1){1'b0}}, 1'b1};
          pend_r     <= '0;
          if (init_cnt_r == AW'(NREG - 1)) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          init_done_r <= 1'b1;
          we_r        <= |gnt_s;
          waddr_r     <= wr_addr_s;
          wdata_r     <= wr_data_s;
          pend_r      <= pend_next_s;
        end
        default: begin
          state_r <= ST_INIT;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomized bench for reg_wb_arbiter against a cycle-level reference model.
module tb_reg_wb_arbiter;
  import reg_wb_arbiter_pkg::*;

  logic clk;
  logic rst_n;

  reg_wb_arbiter_if bus();

  reg_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  bit  [7:0]  m_pend;
  bit         m_last_mem;
  int         m_k;
  bit         exp_we;
  bit  [2:0]  exp_waddr;
  bit  [15:0] exp_wdata;
  logic [15:0] m_rf [8];
  logic [15:0] tb_rf [8];
  bit         g_alu, g_mem;

  // requester hold state for random stimulus
  bit         a_v, m_v;
  bit  [2:0]  a_a, m_a;
  bit  [15:0] a_d, m_d;

  // external register file fed by the DUT write port
  always @(posedge clk) begin
    if (bus.we === 1'b1) tb_rf[bus.waddr] <= bus.wdata;
  end

  property p_alu_hold;
    @(posedge clk) disable iff (!rst_n)
      (bus.alu_valid && !bus.alu_ready) |=> (bus.alu_valid && $stable(bus.alu_addr) && $stable(bus.alu_data));
  endproperty
  a_alu_hold: assert property (p_alu_hold) else $error("alu request withdrawn before acceptance");

  property p_mem_hold;
    @(posedge clk) disable iff (!rst_n)
      (bus.mem_valid && !bus.mem_ready) |=> (bus.mem_valid && $stable(bus.mem_addr) && $stable(bus.mem_data));
  endproperty
  a_mem_hold: assert property (p_mem_hold) else $error("mem request withdrawn before acceptance");

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic step(input bit av, input bit [2:0] aa, input bit [15:0] ad,
                      input bit mv, input bit [2:0] ma, input bit [15:0] md,
                      input bit iv, input bit [2:0] ia, input bit [2:0] r1, input bit [2:0] r2);
    bit run, ga, gm;
    bus.alu_valid = av;  bus.alu_addr = aa;  bus.alu_data = ad;
    bus.mem_valid = mv;  bus.mem_addr = ma;  bus.mem_data = md;
    bus.issue_valid = iv; bus.issue_addr = ia;
    bus.raddr1 = r1;     bus.raddr2 = r2;
    #1;
    run = (m_k >= 9);
    ga  = run && av && (!mv || m_last_mem);
    gm  = run && mv && (!av || !m_last_mem);
    chk("alu_ready", 32'(bus.alu_ready), 32'(ga));
    chk("mem_ready", 32'(bus.mem_ready), 32'(gm));
    chk("ra_haz", 32'(bus.ra_haz), 32'(m_pend[r1]));
    chk("rb_haz", 32'(bus.rb_haz), 32'(m_pend[r2]));
    chk("wd_haz", 32'(bus.wd_haz), 32'(m_pend[ia]));
    g_alu = ga;
    g_mem = gm;
    if (exp_we) m_rf[exp_waddr] = exp_wdata;
    if (m_k < 8) begin
      exp_we = 1'b1; exp_waddr = 3'(m_k); exp_wdata = 16'h0000;
    end else if (ga) begin
      exp_we = 1'b1; exp_waddr = aa; exp_wdata = ad;
    end else if (gm) begin
      exp_we = 1'b1; exp_waddr = ma; exp_wdata = md;
    end else begin
      exp_we = 1'b0;
    end
    if (ga) m_pend[aa] = 1'b0;
    if (gm) m_pend[ma] = 1'b0;
    if (run && iv) m_pend[ia] = 1'b1;
    if (ga) m_last_mem = 1'b0;
    if (gm) m_last_mem = 1'b1;
    if (m_k < 1000) m_k++;
    @(negedge clk);
    chk("we", 32'(bus.we), 32'(exp_we));
    if (exp_we) begin
      chk("waddr", 32'(bus.waddr), 32'(exp_waddr));
      chk("wdata", 32'(bus.wdata), 32'(exp_wdata));
    end
    chk("init_done", 32'(bus.init_done), 32'(m_k >= 9));
    if (m_k >= 9) chk("rd1", 32'(tb_rf[r1]), 32'(m_rf[r1]));
  endtask

  task automatic idle(input bit [2:0] ia, input bit [2:0] r1, input bit [2:0] r2);
    step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, ia, r1, r2);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_init_done", 32'(bus.init_done), 32'd0);
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    m_k = 0; m_pend = 8'h00; m_last_mem = 1'b1; exp_we = 1'b0;
    g_alu = 1'b0; g_mem = 1'b0;
    repeat (cycles) @(negedge clk);
    chk("rst_waddr", 32'(bus.waddr), 32'd0);
    chk("rst_wdata", 32'(bus.wdata), 32'd0);
    chk("rst_haz", 32'({bus.ra_haz, bus.rb_haz, bus.wd_haz}), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic run_random(input int n);
    bit iv;
    bit [2:0] ia;
    for (int i = 0; i < n; i++) begin
      if (!a_v || g_alu) begin
        a_v = ($urandom % 4) != 0; a_a = 3'($urandom_range(0, 7)); a_d = 16'($urandom);
      end
      if (!m_v || g_mem) begin
        m_v = ($urandom % 3) != 0; m_a = 3'($urandom_range(0, 7)); m_d = 16'($urandom);
      end
      ia = 3'($urandom_range(0, 7));
      iv = (($urandom % 3) == 0) && !m_pend[ia];
      step(a_v, a_a, a_d, m_v, m_a, m_d, iv, ia,
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_addr = 3'd0; bus.alu_data = 16'h0000;
    bus.mem_valid = 1'b0; bus.mem_addr = 3'd0; bus.mem_data = 16'h0000;
    bus.issue_valid = 1'b0; bus.issue_addr = 3'd0;
    bus.raddr1 = 3'd0; bus.raddr2 = 3'd0;
    a_v = 1'b0; m_v = 1'b0;
    #2;
    do_reset(3);

    // clear sequence
    repeat (9) idle(3'd0, 3'd0, 3'd0);

    // ALU alone
    step(1'b1, 3'd2, 16'h0625, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd0);
    idle(3'd0, 3'd2, 3'd0);
    idle(3'd0, 3'd2, 3'd0);
    chk("rf2", 32'(tb_rf[2]), 32'h0625);

    // MEM alone, then contention on the same destination
    step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 16'h7777, 1'b0, 3'd0, 3'd0, 3'd0);
    step(1'b1, 3'd3, 16'h00CB, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 3'd3, 3'd0);
    step(1'b1, 3'd4, 16'h0001, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 3'd3, 3'd0);
    step(1'b1, 3'd4, 16'h0001, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd4);
    idle(3'd0, 3'd3, 3'd4);
    idle(3'd0, 3'd4, 3'd3);
    chk("rf3", 32'(tb_rf[3]), 32'h1234);
    chk("rf4", 32'(tb_rf[4]), 32'h0001);
    chk("rf7", 32'(tb_rf[7]), 32'h7777);

    // RAW on register 5 resolved by a load
    step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd0, 3'd5);
    idle(3'd5, 3'd0, 3'd5);
    step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h5555, 1'b0, 3'd5, 3'd0, 3'd5);
    idle(3'd5, 3'd5, 3'd5);

    // issue and retire to register 6 on the same edge
    step(1'b1, 3'd6, 16'h0666, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd6, 3'd6);
    idle(3'd6, 3'd6, 3'd6);
    #1;
    chk("pend6_kept", 32'(bus.wd_haz), 32'd1);
    @(negedge clk);

    run_random(1500);

    // reset in the middle of traffic with an ALU request held
    a_v = 1'b1; a_a = 3'd1; a_d = 16'hBEEF;
    bus.alu_valid = a_v; bus.alu_addr = a_a; bus.alu_data = a_d;
    do_reset(2);
    run_random(1500);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
